// File: rtl/obc_dft_pkg.sv
// Shared constants, state encoding and width helpers for the OBC DFT bin sequencer.
package obc_dft_pkg;

    localparam int DEF_DATA_W  = 16;
    localparam int DEF_COEF_W  = 32;
    localparam int NUM_SAMPLES = 16;
    localparam int NUM_WORDS   = 8;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_COMPUTE,
        ST_FINAL,
        ST_OUT
    } state_t;

    function automatic int sum_w(input int coef_w);
        return coef_w + 3;
    endfunction

    // Accumulator holds the 8-word sum shifted across every bit-plane.
    function automatic int acc_w(input int data_w, input int coef_w);
        return coef_w + 3 + data_w;
    endfunction

endpackage

// File: rtl/obc_dft_sequencer_if.sv
// Sample/ROM/result bundle between the sequencer (master) and its surroundings (slave).
interface obc_dft_sequencer_if
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W
);
    localparam int ACC_W = acc_w(DATA_W, COEF_W);

    logic                           in_valid;
    logic                           in_ready;
    logic [DATA_W-1:0]              in_sample;
    logic [NUM_SAMPLES-1:0]         rom_bits;
    logic [NUM_WORDS*COEF_W-1:0]    rom_data;
    logic                           out_valid;
    logic                           out_ready;
    logic signed [ACC_W-1:0]        out_data;
    logic                           busy;

    modport master (
        input  in_valid, in_sample, rom_data, out_ready,
        output in_ready, rom_bits, out_valid, out_data, busy
    );

    modport slave (
        output in_valid, in_sample, rom_data, out_ready,
        input  in_ready, rom_bits, out_valid, out_data, busy
    );

endinterface

// File: rtl/obc_rom_sum.sv
// Sign-extending sum of the eight ROM partial words for the current bit-plane.
module obc_rom_sum
    import obc_dft_pkg::*;
#(
    parameter  int COEF_W = DEF_COEF_W,
    localparam int SUM_W  = sum_w(COEF_W)
) (
    input  logic [NUM_WORDS*COEF_W-1:0] i_rom_data,
    output logic signed [SUM_W-1:0]     o_sum
);

    always_comb begin
        o_sum = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            o_sum = o_sum + SUM_W'($signed(i_rom_data[j*COEF_W +: COEF_W]));
        end
    end

endmodule

// File: rtl/obc_dft_sequencer.sv
// Bit-serial OBC sequencer for one DFT bin: load 16 samples, shift-accumulate
// one ROM bit-plane per cycle MSB first, then hand the result downstream.
//
//  state      | meaning
//  LOAD       | accepting samples x0..x15
//  COMPUTE    | one bit-plane per cycle, MSB (sign) plane first
//  FINAL      | add OBC offset
//  OUT        | result held until downstream accepts
module obc_dft_sequencer
    import obc_dft_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int COEF_W = DEF_COEF_W,
    parameter logic signed [acc_w(DATA_W, COEF_W)-1:0] OFFSET = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    obc_dft_sequencer_if.master  io_bus
);

    localparam int SUM_W   = sum_w(COEF_W);
    localparam int ACC_W   = acc_w(DATA_W, COEF_W);
    localparam int PLANE_W = $clog2(DATA_W);
    localparam logic [PLANE_W-1:0] PLANE_TOP = PLANE_W'(DATA_W - 1);

    state_t                   r_state;
    logic [3:0]               r_smp_cnt;
    logic [PLANE_W-1:0]       r_plane;
    logic [DATA_W-1:0]        r_sample [NUM_SAMPLES];
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_in_ready;
    logic                     r_out_valid;
    logic                     r_busy;

    logic [NUM_SAMPLES-1:0]   w_rom_bits;
    logic signed [SUM_W-1:0]  w_sum;
    logic signed [ACC_W-1:0]  w_sum_ext;

    always_comb begin
        w_rom_bits = '0;
        if (r_state == ST_COMPUTE) begin
            for (int k = 0; k < NUM_SAMPLES; k++) begin
                w_rom_bits[k] = r_sample[k][r_plane];
            end
        end
    end

    obc_rom_sum #(.COEF_W(COEF_W)) u_rom_sum (
        .i_rom_data (io_bus.rom_data),
        .o_sum      (w_sum)
    );

    assign w_sum_ext = ACC_W'(w_sum);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_LOAD;
            r_smp_cnt   <= '0;
            r_plane     <= '0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            for (int k = 0; k < NUM_SAMPLES; k++) begin
                r_sample[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (io_bus.in_valid) begin
                        r_sample[r_smp_cnt] <= io_bus.in_sample;
                        r_smp_cnt           <= r_smp_cnt + 4'd1;
                        if (r_smp_cnt == 4'd15) begin
                            r_state    <= ST_COMPUTE;
                            r_plane    <= PLANE_TOP;
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                        end
                    end
                end
                ST_COMPUTE: begin
                    // The MSB plane carries negative weight in two's complement.
                    if (r_plane == PLANE_TOP) begin
                        r_acc <= -w_sum_ext;
                    end else begin
                        r_acc <= (r_acc <<< 1) + w_sum_ext;
                    end
                    r_plane <= r_plane - PLANE_W'(1);
                    if (r_plane == '0) begin
                        r_state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    r_acc       <= r_acc + OFFSET;
                    r_state     <= ST_OUT;
                    r_out_valid <= 1'b1;
                end
                ST_OUT: begin
                    if (io_bus.out_ready) begin
                        r_state     <= ST_LOAD;
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_LOAD;
            endcase
        end
    end

    assign io_bus.in_ready  = r_in_ready;
    assign io_bus.out_valid = r_out_valid;
    assign io_bus.out_data  = r_acc;
    assign io_bus.busy      = r_busy;
    assign io_bus.rom_bits  = w_rom_bits;

endmodule

// File: tb/tb_obc_dft_sequencer.sv
// Bench for obc_dft_sequencer: two instances (OFFSET 0 and 5) driven in lock-step,
// pair-XOR ROM stub, results compared against a plane-weighted popcount model.
module tb_obc_dft_sequencer;
    import obc_dft_pkg::*;

    localparam int DATA_W = 16;
    localparam int COEF_W = 32;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W);

    logic clk;
    logic rst_n;
    int   n_cmp = 0;
    int   n_mis = 0;

    obc_dft_sequencer_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) if0 ();
    obc_dft_sequencer_if #(.DATA_W(DATA_W), .COEF_W(COEF_W)) if5 ();

    obc_dft_sequencer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OFFSET(ACC_W'(0))) dut0 (
        .clk(clk), .rst_n(rst_n), .io_bus(if0.master)
    );
    obc_dft_sequencer #(.DATA_W(DATA_W), .COEF_W(COEF_W), .OFFSET(ACC_W'(5))) dut5 (
        .clk(clk), .rst_n(rst_n), .io_bus(if5.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        if0.rom_data = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            if0.rom_data[j*COEF_W] = if0.rom_bits[2*j] ^ if0.rom_bits[2*j+1];
        end
    end

    always_comb begin
        if5.rom_data = '0;
        for (int j = 0; j < NUM_WORDS; j++) begin
            if5.rom_data[j*COEF_W] = if5.rom_bits[2*j] ^ if5.rom_bits[2*j+1];
        end
    end

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Result = sum over planes of weight(b) * number of pairs (x_2j, x_2j+1) differing in bit b.
    function automatic longint model(input logic [15:0] x [16]);
        longint r;
        longint s;
        r = 0;
        for (int b = 0; b < DATA_W; b++) begin
            s = 0;
            for (int j = 0; j < 8; j++) begin
                s += longint'(x[2*j][b] ^ x[2*j+1][b]);
            end
            if (b == DATA_W - 1) r -= s * (longint'(1) << b);
            else                 r += s * (longint'(1) << b);
        end
        return r;
    endfunction

    function automatic logic [15:0] plane_bits(input logic [15:0] x [16], input int b);
        logic [15:0] r;
        for (int k = 0; k < 16; k++) r[k] = x[k][b];
        return r;
    endfunction

    task automatic drv(input logic v, input logic [15:0] s, input logic ordy);
        if0.in_valid = v;  if5.in_valid = v;
        if0.in_sample = s; if5.in_sample = s;
        if0.out_ready = ordy; if5.out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_frame(input logic [15:0] x [16], input bit gaps, input int hold,
                             input bit early, input bit abort);
        int     acc_n;
        int     cyc;
        int     lat;
        longint e0;
        logic   v;
        logic   rdy;
        acc_n = 0;
        cyc   = 0;
        e0    = model(x);
        while (acc_n < 16 && cyc < 100) begin
            v = !gaps || (cyc % 2 == 1);
            drv(v, x[acc_n], 1'b0);
            rdy = if0.in_ready;
            @(posedge clk);
            if (v && rdy) acc_n++;
            #1;
            cyc++;
        end
        chk("load_accepts", acc_n, 16);
        drv(1'b0, 16'h0, early);
        chk("compute_busy", if0.busy, 1);
        chk("compute_in_ready", if0.in_ready, 0);
        chk("rom_bits_msb_plane", if0.rom_bits, plane_bits(x, 15));
        if (abort) begin
            repeat (8) step();
            chk("rom_bits_plane7", if0.rom_bits, plane_bits(x, 7));
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            chk("abort_in_ready", if0.in_ready, 1);
            chk("abort_out_valid", if0.out_valid, 0);
            chk("abort_busy", if0.busy, 0);
            chk("abort_out_data", 64'(if0.out_data), 0);
            return;
        end
        lat = 0;
        while (!if0.out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", lat, 17);
        chk("rom_bits_idle_out", if0.rom_bits, 0);
        chk("out_data_off0", 64'(if0.out_data), e0);
        chk("out_data_off5", 64'(if5.out_data), e0 + 5);
        if (!early && hold > 0) begin
            repeat (hold) step();
            chk("hold_out_valid", if0.out_valid, 1);
            chk("hold_out_data", 64'(if0.out_data), e0);
            chk("hold_in_ready", if0.in_ready, 0);
        end
        drv(1'b0, 16'h0, 1'b1);
        step();
        chk("post_xfer_in_ready", if0.in_ready, 1);
        chk("post_xfer_out_valid", if0.out_valid, 0);
        chk("post_xfer_busy", if5.busy, 0);
        drv(1'b0, 16'h0, 1'b0);
    endtask

    initial begin
        logic [15:0] x [16];

        rst_n = 1'b0;
        drv(1'b0, 16'h0, 1'b0);
        repeat (3) step();
        rst_n = 1'b1;
        chk("rst_in_ready", if0.in_ready, 1);
        chk("rst_out_valid", if0.out_valid, 0);
        chk("rst_out_data", 64'(if0.out_data), 0);
        chk("rst_rom_bits", if0.rom_bits, 0);
        chk("rst_busy", if0.busy, 0);
        chk("rst_out_data5", 64'(if5.out_data), 0);

        foreach (x[k]) x[k] = 16'h0;
        x[0] = 16'h0001;
        run_frame(x, 1'b0, 0, 1'b0, 1'b0);

        x[0] = 16'h8000;
        run_frame(x, 1'b0, 0, 1'b0, 1'b0);

        x[0] = 16'hFFFF; x[1] = 16'hFFFF;
        run_frame(x, 1'b0, 0, 1'b0, 1'b0);

        foreach (x[k]) x[k] = 16'h0;
        x[0] = 16'h0003; x[2] = 16'h0001;
        run_frame(x, 1'b0, 10, 1'b0, 1'b0);
        run_frame(x, 1'b1, 0, 1'b0, 1'b0);

        for (int f = 0; f < 6; f++) begin
            foreach (x[k]) x[k] = 16'($urandom);
            run_frame(x, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), 1'b0);
        end

        foreach (x[k]) x[k] = 16'($urandom);
        run_frame(x, 1'b0, 0, 1'b0, 1'b1);
        foreach (x[k]) x[k] = 16'($urandom);
        run_frame(x, 1'b0, 2, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
